// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with branch/jump redirect, call/return and flush generation.
// Define RAS_EN for a RAS_DEPTH-entry return-address stack; otherwise a single link register is used.
module pc_sequencer #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              call,
    input  logic [ADDR_W-1:0] call_ret_addr,
    input  logic              ret,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_plus_one,
    output logic              fetch_valid,
    output logic              flush,
    output logic              halted,
    output logic              ras_overflow,
    output logic              ras_underflow
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED} state_t;

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of 2 in 2..16");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              run, push, pop_req, ret_take;
    logic [ADDR_W-1:0] ret_addr;

    assign run     = state_q == S_RUN;
    assign push    = run && redirect && call;
    // A ret coinciding with a redirect is dropped entirely.
    assign pop_req = run && !redirect && ret;

`ifdef RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] SP_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     sp_q, sp_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              empty, full;

    assign empty    = cnt_q == '0;
    assign full     = cnt_q == CNT_FULL;
    assign ret_take = pop_req && !empty;
    assign ret_addr = ras_mem[sp_q - SP_ONE];

    // sp points at the next free slot; wrapping overwrites the oldest entry when full.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | (push && full);
        unf_d = unf_q | (pop_req && empty);
        if (push) begin
            sp_d  = sp_q + SP_ONE;
            cnt_d = full ? cnt_q : cnt_q + CNT_ONE;
        end else if (ret_take) begin
            sp_d  = sp_q - SP_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras_mem[sp_q] <= call_ret_addr;
    end

    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    logic [ADDR_W-1:0] link_q, link_d;

    assign link_d   = push ? call_ret_addr : link_q;
    assign ret_take = pop_req;
    assign ret_addr = link_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) link_q <= RESET_VEC;
        else        link_q <= link_d;
    end

    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_RUN;
            S_HALTED: if (resume) state_d = S_RUN;
            default: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    flush_d = 1'b1;
                end else if (ret_take) begin
                    pc_d    = ret_addr;
                    flush_d = 1'b1;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else if (!stall) begin
                    pc_d = PC_plus_one;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign PC          = pc_q;
    assign PC_plus_one = pc_q + ADDR_W'(1);
    assign fetch_valid = state_q == S_RUN;
    assign halted      = state_q == S_HALTED;
    assign flush       = flush_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the CPU fetch stage. It owns the PC register and advances it each cycle. It applies redirects resolved by the branch unit (taken branch or jump), handles call/return through a small return-address stack, and generates the one-cycle fetch flush that squashes wrong-path instructions. Stall, halt and resume inputs come from the hazard/debug logic.

## Interface
Parameters:
- ADDR_W, 16, PC/address width
- RESET_VEC, 16'h0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of 2, 2..16)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  hold PC this cycle
- halt  in  1  request entry to HALTED
- resume  in  1  leave HALTED
- redirect  in  1  branch unit PC_select: taken branch or jump
- redirect_pc  in  ADDR_W  branch unit PC_next: target address
- call  in  1  qualifies redirect as a call; push call_ret_addr
- call_ret_addr  in  ADDR_W  branch unit PC_return: link address
- ret  in  1  return request; pop the stack and redirect to the popped address
- PC  out  ADDR_W  current fetch address
- PC_plus_one  out  ADDR_W  PC+1 mod 2^ADDR_W
- fetch_valid  out  1  PC is a valid fetch address
- flush  out  1  one-cycle pulse: squash in-flight fetches
- halted  out  1  state is HALTED
- ras_overflow  out  1  sticky: push while stack full
- ras_underflow  out  1  sticky: ret while stack empty

## Operation
- States: RESET, RUN, HALTED.
  - RESET: entered asynchronously on rst_n low. Leaves to RUN at the first posedge with rst_n high.
  - RUN: leaves to HALTED on halt.
  - HALTED: leaves to RUN on resume.
- Reset values:
  - PC = RESET_VEC, PC_plus_one = RESET_VEC+1.
  - fetch_valid, flush, halted, ras_overflow, ras_underflow = 0.
  - Stack empty (count 0).
- Per-cycle priority in RUN:
  - 1. redirect: PC <= redirect_pc, flush next cycle. If call is also high, push call_ret_addr.
  - 2. ret with stack not empty: PC <= top of stack, pop, flush next cycle.
  - 3. halt: go to HALTED, PC held.
  - 4. stall: PC held.
  - 5. otherwise: PC <= PC_plus_one.
- redirect overrides stall and halt in the same cycle.
- A ret in the same cycle as redirect is ignored; the stack is not popped.
- ret with stack empty:
  - ras_underflow set.
  - No flush; the cycle falls through to priority 3..5.
- Push while stack full:
  - Oldest entry overwritten (circular); count saturates at RAS_DEPTH.
  - ras_overflow set.
- Sticky flags clear only on reset.
- HALTED:
  - PC held, fetch_valid = 0.
  - redirect, ret, call and stall are ignored.
  - resume returns to RUN next cycle with PC unchanged.
  - halt and resume together: resume wins.
- PC increment wraps: 16'hFFFF -> 16'h0000.
- PC_plus_one is combinational from PC.
- fetch_valid = 1 in RUN, 0 in RESET and HALTED.

## Timing
- All state is registered on posedge clk; rst_n clears asynchronously.
- Redirect or ret accepted at edge n: PC shows the target after edge n, and flush = 1 for exactly that cycle.
- Back-to-back redirects: each updates PC. flush stays high for consecutive cycles, with no gap and no merge.
- Push and pop both take effect at the accepting edge. The top of stack is available to a ret in the very next cycle.
- Reset asserted mid-operation (including during a flush cycle): all outputs return to reset values immediately; the stack is emptied.

## Configuration
- RAS_EN defined: full RAS_DEPTH return-address stack, with overflow and underflow detection as above.
- RAS_EN undefined:
  - A single link register replaces the stack; call overwrites it.
  - ret always redirects to the link register (RESET_VEC after reset) and flushes.
  - ras_overflow and ras_underflow are tied to 0; RAS_DEPTH is ignored.

## Test plan
- Reset then free-run: release rst_n, run 5 cycles -> PC 0000, then fetch_valid=1 and PC 0000,0001,0002,0003. Start from PC=FFFF -> next PC 0000.
- Redirect under stall: stall=1 and redirect=1 with redirect_pc=1234 -> PC=1234 next cycle, flush=1 for one cycle. Next cycle stall=1 alone -> PC holds 1234.
- Call/return (RAS_EN): call to 0100 with link 0051, then call to 0200 with link 0101, then ret, ret -> PC goes 0100, 0200, 0101, 0051. Four flush pulses; no flags set.
- Overflow/underflow (RAS_EN, depth 4): 5 calls with links 0001..0005 -> ras_overflow=1. Then 4 rets -> PC 0005, 0004, 0003, 0002. A 5th ret -> ras_underflow=1, no flush, PC increments.
- Halt/resume: halt at PC=0040 -> halted=1, fetch_valid=0, PC holds 0040, redirect ignored. Resume -> RUN next cycle, PC continues 0040, 0041.
- Reset mid-flush: assert rst_n low in the cycle flush=1 -> flush=0 and PC=RESET_VEC immediately; stack empty.
